// File: rtl/vcve2_vlsu_sequencer.sv
// Vector load/store sequencer: walks the elements of one vector register through the
// scalar LSU one request at a time, writing load data back into the VRF.
module vcve2_vlsu_sequencer #(
   parameter int unsigned NumElem = 8
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            start_i,
   input  logic                            is_store_i,
   input  logic [4:0]                      vd_i,
   input  logic [$clog2(NumElem):0]        vl_i,
   input  logic [31:0]                     base_addr_i,
   output logic                            load_start_o,
   output logic [31:0]                     start_addr_o,
   output logic                            vec_op_o,
   output logic                            vrf_req_o,
   output logic [31:0]                     vrf_data_o,
   input  logic                            vrf_lsu_gnt_i,
   input  logic                            lsu_resp_valid_i,
   input  logic [31:0]                     lsu_rdata_i,
   input  logic                            lsu_err_i,
   output logic [4+$clog2(NumElem):0]      vrf_raddr_o,
   input  logic [31:0]                     vrf_rdata_i,
   output logic                            vrf_we_o,
   output logic [4+$clog2(NumElem):0]      vrf_waddr_o,
   output logic [31:0]                     vrf_wdata_o,
   output logic                            busy_o,
   output logic                            done_o,
   output logic                            err_o
);

   localparam int unsigned IW = $clog2(NumElem);
   localparam int unsigned VW = IW + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_e;

   state_e         state, state_nxt;
   logic           is_store, is_store_nxt;
   logic [4:0]     vd, vd_nxt;
   logic [VW-1:0]  vl, vl_nxt;
   logic [VW-1:0]  idx, idx_nxt;
   logic [VW-1:0]  idx_inc;
   logic [VW-1:0]  vl_clamp;
   logic           err, err_nxt;

   // Oversized lengths are limited to one full register.
   assign vl_clamp     = (vl_i > VW'(NumElem)) ? VW'(NumElem) : vl_i;
   assign idx_inc      = idx + VW'(1);
   assign start_addr_o = base_addr_i;
   assign busy_o       = (state != IDLE);
   assign err_o        = err;

   // State and latched operation context.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= IDLE;
         is_store <= 1'b0;
         vd       <= 5'd0;
         vl       <= '0;
         idx      <= '0;
         err      <= 1'b0;
      end else begin
         state    <= state_nxt;
         is_store <= is_store_nxt;
         vd       <= vd_nxt;
         vl       <= vl_nxt;
         idx      <= idx_nxt;
         err      <= err_nxt;
      end
   end

   // Next-state and per-state output decode.
   always_comb begin
      state_nxt    = state;
      is_store_nxt = is_store;
      vd_nxt       = vd;
      vl_nxt       = vl;
      idx_nxt      = idx;
      err_nxt      = err;
      load_start_o = 1'b0;
      vec_op_o     = 1'b0;
      vrf_req_o    = 1'b0;
      vrf_data_o   = 32'd0;
      vrf_raddr_o  = '0;
      vrf_we_o     = 1'b0;
      vrf_waddr_o  = '0;
      vrf_wdata_o  = 32'd0;
      done_o       = 1'b0;
      case (state)
         IDLE: begin
            if (start_i) begin
               load_start_o = 1'b1;
               is_store_nxt = is_store_i;
               vd_nxt       = vd_i;
               vl_nxt       = vl_clamp;
               idx_nxt      = '0;
               err_nxt      = 1'b0;
               state_nxt    = (vl_clamp != '0) ? REQ : DONE;
            end else begin
               state_nxt    = IDLE;
            end
         end
         REQ: begin
            vec_op_o    = 1'b1;
            vrf_req_o   = 1'b1;
            vrf_raddr_o = {vd, idx[IW-1:0]};
            if (is_store) begin
               vrf_data_o = vrf_rdata_i;
            end else begin
               vrf_data_o = 32'd0;
            end
            if (vrf_lsu_gnt_i) begin
               state_nxt = WAIT;
            end else begin
               state_nxt = REQ;
            end
         end
         WAIT: begin
            vec_op_o = 1'b1;
            if (lsu_resp_valid_i) begin
               if (lsu_err_i) begin
                  err_nxt   = 1'b1;
                  state_nxt = DONE;
               end else begin
                  if (!is_store) begin
                     vrf_we_o    = 1'b1;
                     vrf_waddr_o = {vd, idx[IW-1:0]};
                     vrf_wdata_o = lsu_rdata_i;
                  end else begin
                     vrf_we_o    = 1'b0;
                  end
                  idx_nxt   = idx_inc;
                  state_nxt = (idx_inc == vl) ? DONE : REQ;
               end
            end else begin
               state_nxt = WAIT;
            end
         end
         DONE: begin
            done_o    = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: doc/vcve2_vlsu_sequencer.md
VCVE2_VLSU_SEQUENCER -- requirements
Module: vcve2_vlsu_sequencer

Interface
REQ-001 SHALL have parameter NumElem, default 8, meaning elements per vector register (power of two, 2..16).
REQ-002 SHALL have ports, clock and reset first:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  vector memory op start, sampled in IDLE only
- is_store_i  in  1  1 = store, 0 = load
- vd_i  in  5  vector register index
- vl_i  in  $clog2(NumElem)+1  element count, 0..NumElem
- base_addr_i  in  32  first element address
- load_start_o  out  1  pulse: address counter loads start_addr_o
- start_addr_o  out  32  equals base_addr_i
- vec_op_o  out  1  LSU owned by vector path
- vrf_req_o  out  1  per-element LSU request
- vrf_data_o  out  32  store data
- vrf_lsu_gnt_i  in  1  LSU grant (vector-qualified)
- lsu_resp_valid_i  in  1  LSU response valid
- lsu_rdata_i  in  32  load data
- lsu_err_i  in  1  response error, valid with lsu_resp_valid_i
- vrf_raddr_o  out  5+$clog2(NumElem)  {vreg, elem} read address
- vrf_rdata_i  in  32  VRF read data, combinational from vrf_raddr_o
- vrf_we_o  out  1  VRF write enable
- vrf_waddr_o  out  5+$clog2(NumElem)  {vreg, elem} write address
- vrf_wdata_o  out  32  VRF write data
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  sticky error of current/last op
REQ-003 SHALL use clock clk_i and reset rst_ni, asynchronous, active-low.

Function
REQ-004 SHALL implement FSM IDLE, REQ, WAIT, DONE.
REQ-005 IDLE with start_i=1: load_start_o=1 same cycle (combinational), latch is_store_i, vd_i, vl_i; clear elem index and err; next REQ if vl_i>0, else DONE.
REQ-006 IDLE with start_i=0: hold; start_i in any other state SHALL be ignored.
REQ-007 REQ: vrf_req_o=1, vec_op_o=1, vrf_raddr_o={vd,idx}, vrf_data_o=vrf_rdata_i for stores, 0 for loads; on vrf_lsu_gnt_i=1 -> WAIT, else stay REQ with outputs held.
REQ-008 WAIT: vec_op_o=1, vrf_req_o=0; wait for lsu_resp_valid_i; at most one outstanding request.
REQ-009 WAIT with resp valid, load, lsu_err_i=0: vrf_we_o=1, vrf_waddr_o={vd,idx}, vrf_wdata_o=lsu_rdata_i, same cycle.
REQ-010 WAIT with resp valid, lsu_err_i=0: idx+1; if idx+1==vl -> DONE else REQ.
REQ-011 WAIT with resp valid, lsu_err_i=1: no VRF write, err set, -> DONE (remaining elements abandoned).
REQ-012 DONE: done_o=1 one cycle, vec_op_o=0, -> IDLE.
REQ-013 lsu_resp_valid_i outside WAIT SHALL be ignored; no VRF write.
REQ-014 Idx width $clog2(NumElem)+1; never exceeds vl; vl_i>NumElem SHALL be clamped to NumElem.
REQ-015 Element latency: min 2 cycles (REQ with gnt, WAIT with resp); op of vl=N with immediate gnt/resp completes with done_o at cycle 2N+1 after start.
REQ-016 err_o SHALL hold until next accepted start.

Reset
REQ-017 On rst_ni=0, any state: FSM -> IDLE, idx=0, err_o=0; all outputs 0 except start_addr_o (=base_addr_i) and vrf_data_o (0); no VRF write asserted.
REQ-018 Reset mid-operation SHALL abandon op without done_o pulse.

Verification
REQ-019 Load vl=4, vd=3, gnt/resp immediate, rdata 0xA0..0xA3 -> four writes {3,0..3} data 0xA0..0xA3, done_o at cycle 9, err_o=0.
REQ-020 Store vl=2, gnt withheld 3 cycles -> vrf_req_o held 4 cycles, vrf_data_o stable = vrf_rdata_i for {vd,0}, no vrf_we_o.
REQ-021 vl=0 start -> load_start_o pulse, done_o next cycle, vrf_req_o never asserted.
REQ-022 Load vl=4, lsu_err_i on element 1 -> one write (elem 0), done_o, err_o=1 until next start.
REQ-023 start_i asserted during WAIT and spurious resp in IDLE -> ignored, no state or VRF change.
REQ-024 rst_ni low during WAIT of element 2 -> outputs 0 asynchronously, no done_o; subsequent start operates normally.
